// File: rtl/write_burst_scheduler.sv
// Command-side sequencer for write_fsm: queues write commands and drives
// wr_en, burst length, CRC mode, interamble flag and gap cycle by cycle.
module write_burst_scheduler #(
  parameter int DEPTH              = 4,
  parameter int INTERAMBLE_MAX_GAP = 2,
  parameter int CW                 = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [1:0]    i_cmd_bl,
  input  logic          i_cmd_crc,
  input  logic [3:0]    i_cmd_gap,
  output logic          o_wr_en,
  output logic [1:0]    o_burstlength,
  output logic          o_crc_generate,
  output logic          o_interamble,
  output logic [3:0]    o_gap,
  output logic          o_busy,
  output logic [CW-1:0] o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] IA_MAX = 4'(INTERAMBLE_MAX_GAP);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  // bl8 is the normalised burst code: only 2'b01 selects BL8, all else is BL16.
  typedef struct packed {
    logic       bl8;
    logic       crc;
    logic [3:0] gap;
  } cmd_t;

  state_t          state, state_nx;
  cmd_t            mem [DEPTH];
  cmd_t            cmd_in, head, cur, src;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [3:0]      gap_cnt, beat_cnt;
  logic            push, pop, fifo_empty, load_burst, load_wait;

  function automatic logic [3:0] burst_len(input cmd_t c);
    return (c.bl8 ? 4'd4 : 4'd8) + {3'b000, c.crc};
  endfunction

  // Handshake: a command transfers on a rising edge where i_cmd_valid and
  // o_cmd_ready are both high; ready depends only on registered count and enable.
  assign o_cmd_ready  = (count != CW'(DEPTH)) & i_enable;
  assign push         = i_cmd_valid & o_cmd_ready;
  assign cmd_in       = {(i_cmd_bl == 2'b01), i_cmd_crc, i_cmd_gap};
  assign head         = mem[rd_ptr];
  assign fifo_empty   = (count == '0);
  assign o_wr_en      = (state == S_BURST);
  assign o_busy       = (state != S_IDLE) | ~fifo_empty;
  assign o_fifo_count = count;

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    load_burst = 1'b0;
    load_wait  = 1'b0;
    src        = head;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.gap == 4'd0) begin
            state_nx   = S_BURST;
            load_burst = 1'b1;
          end else begin
            state_nx  = S_WAIT;
            load_wait = 1'b1;
          end
        end
      end
      S_WAIT: begin
        src = cur;
        if (gap_cnt <= 4'd1) begin
          state_nx   = S_BURST;
          load_burst = 1'b1;
        end
      end
      S_BURST: begin
        if (beat_cnt <= 4'd1) begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head.gap == 4'd0) begin
              load_burst = 1'b1;
            end else begin
              state_nx  = S_WAIT;
              load_wait = 1'b1;
            end
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_enable && push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cur            <= '0;
      gap_cnt        <= '0;
      beat_cnt       <= '0;
      o_burstlength  <= 2'b00;
      o_crc_generate <= 1'b0;
      o_interamble   <= 1'b0;
      o_gap          <= 4'd0;
    end else if (i_enable) begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (load_wait) begin
        cur     <= head;
        gap_cnt <= head.gap;
      end else if (state == S_WAIT) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      if (load_burst) begin
        beat_cnt       <= burst_len(src);
        o_burstlength  <= src.bl8 ? 2'b01 : 2'b00;
        o_crc_generate <= src.crc;
      end else if (state == S_BURST) begin
        beat_cnt <= beat_cnt - 1'b1;
      end

      // Look-ahead to the next queued burst so write_fsm can plan its ending.
      if (state == S_BURST) begin
        if (fifo_empty) begin
          o_gap        <= 4'd0;
          o_interamble <= 1'b0;
        end else begin
          o_gap        <= head.gap;
          o_interamble <= (head.gap != 4'd0) && (head.gap <= IA_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_write_burst_scheduler.sv
// Directed bench for write_burst_scheduler: wr_en waveforms are recorded on the
// falling edge and compared against hand-built run-length patterns.
module tb_write_burst_scheduler;

  logic       i_clk, i_rst, i_enable, i_cmd_valid, o_cmd_ready;
  logic [1:0] i_cmd_bl;
  logic       i_cmd_crc;
  logic [3:0] i_cmd_gap;
  logic       o_wr_en, o_crc_generate, o_interamble, o_busy;
  logic [1:0] o_burstlength;
  logic [3:0] o_gap;
  logic [2:0] o_fifo_count;

  int n_vec = 0;
  int n_bad = 0;

  logic [1023:0] wr_hist = '0;
  int            wr_len  = 0;
  logic [0:0]    exp_q[$];

  write_burst_scheduler #(.DEPTH(4), .INTERAMBLE_MAX_GAP(2), .CW(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_bl(i_cmd_bl), .i_cmd_crc(i_cmd_crc), .i_cmd_gap(i_cmd_gap),
    .o_wr_en(o_wr_en), .o_burstlength(o_burstlength),
    .o_crc_generate(o_crc_generate), .o_interamble(o_interamble),
    .o_gap(o_gap), .o_busy(o_busy), .o_fifo_count(o_fifo_count)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (wr_len < 1024) wr_hist[wr_len] <= o_wr_en;
    wr_len <= wr_len + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // driver
  task automatic push(input logic [1:0] bl, input logic crc, input logic [3:0] gap,
                      output int waited);
    waited      = 0;
    i_cmd_valid = 1'b1;
    i_cmd_bl    = bl;
    i_cmd_crc   = crc;
    i_cmd_gap   = gap;
    while (!o_cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("push_timeout", 64'(o_cmd_ready), 64'd1);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic add_run(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // scoreboard: compare recorded wr_en samples from start against exp_q
  task automatic check_pattern(input string tag, input int start);
    logic [63:0] o, e;
    int k;
    k = 0;
    while (wr_len < start + exp_q.size() && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check({tag, "_timeout"}, 64'(wr_len), 64'(start + exp_q.size()));
    o = '0;
    e = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e[i] = exp_q[i];
      o[i] = wr_hist[start + i];
    end
    check(tag, o, e);
    exp_q.delete();
  endtask

  initial begin
    int start, w;
    i_rst = 1'b0; i_enable = 1'b1; i_cmd_valid = 1'b0;
    i_cmd_bl = 2'b00; i_cmd_crc = 1'b0; i_cmd_gap = 4'd0;
    #12;
    check("rst_wr_en", 64'(o_wr_en), 64'd0);
    check("rst_ready", 64'(o_cmd_ready), 64'd1);
    check("rst_count", 64'(o_fifo_count), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_outs", 64'({o_burstlength, o_crc_generate, o_interamble, o_gap}), 64'd0);
    i_rst = 1'b1;
    tick();

    // single BL16, no CRC
    push(2'b00, 1'b0, 4'd0, w);
    start = wr_len;
    check("t1_count", 64'(o_fifo_count), 64'd1);
    check("t1_busy", 64'(o_busy), 64'd1);
    add_run(0, 1); add_run(1, 8); add_run(0, 3);
    check_pattern("t1_wr_en", start);
    check("t1_bl", 64'(o_burstlength), 64'd0);
    check("t1_crc", 64'(o_crc_generate), 64'd0);
    check("t1_idle", 64'({o_busy, o_fifo_count}), 64'd0);

    // reserved burst code behaves as BL16, with CRC
    push(2'b11, 1'b1, 4'd0, w);
    start = wr_len;
    add_run(0, 1); add_run(1, 9); add_run(0, 2);
    check_pattern("t1b_wr_en", start);
    check("t1b_bl_crc", 64'({o_burstlength, o_crc_generate}), 64'b001);

    // BL8+CRC then BL16 back-to-back
    push(2'b01, 1'b1, 4'd0, w);
    start = wr_len;
    push(2'b00, 1'b0, 4'd0, w);
    check("t2_first", 64'({o_wr_en, o_burstlength, o_crc_generate}), 64'b1011);
    repeat (4) tick();
    check("t2_last_beat", 64'({o_wr_en, o_burstlength, o_crc_generate}), 64'b1011);
    tick();
    check("t2_reload", 64'({o_wr_en, o_burstlength, o_crc_generate}), 64'b1000);
    add_run(0, 1); add_run(1, 13); add_run(0, 2);
    check_pattern("t2_wr_en", start);

    // gap 2 uses interamble
    push(2'b00, 1'b0, 4'd0, w);
    start = wr_len;
    push(2'b00, 1'b0, 4'd2, w);
    tick();
    check("t3_ia", 64'(o_interamble), 64'd1);
    check("t3_gap", 64'(o_gap), 64'd2);
    add_run(0, 1); add_run(1, 8); add_run(0, 2); add_run(1, 8); add_run(0, 2);
    check_pattern("t3_wr_en", start);
    check("t3_ia_end", 64'({o_interamble, o_gap}), 64'd0);

    // gap 5 does not
    push(2'b00, 1'b0, 4'd0, w);
    start = wr_len;
    push(2'b00, 1'b0, 4'd5, w);
    tick();
    check("t4_ia", 64'(o_interamble), 64'd0);
    check("t4_gap", 64'(o_gap), 64'd5);
    add_run(0, 1); add_run(1, 8); add_run(0, 5); add_run(1, 8); add_run(0, 2);
    check_pattern("t4_wr_en", start);

    // fill the FIFO while busy; sixth command held off until first pop
    push(2'b00, 1'b0, 4'd0, w);
    start = wr_len;
    push(2'b01, 1'b1, 4'd1, w);
    push(2'b01, 1'b0, 4'd1, w);
    push(2'b00, 1'b1, 4'd1, w);
    push(2'b01, 1'b0, 4'd1, w);
    check("t5_full_count", 64'(o_fifo_count), 64'd4);
    check("t5_full_ready", 64'(o_cmd_ready), 64'd0);
    push(2'b00, 1'b0, 4'd1, w);
    check("t5_held_cycles", 64'(w), 64'd5);
    check("t5_count_after", 64'(o_fifo_count), 64'd4);
    add_run(0, 1); add_run(1, 8); add_run(0, 1); add_run(1, 5); add_run(0, 1);
    add_run(1, 4); add_run(0, 1); add_run(1, 9); add_run(0, 1); add_run(1, 4);
    add_run(0, 1); add_run(1, 8); add_run(0, 2);
    check_pattern("t5_wr_en", start);

    // async reset on beat 3
    push(2'b00, 1'b0, 4'd0, w);
    push(2'b01, 1'b0, 4'd0, w);
    repeat (2) tick();
    check("t6_beat3", 64'(o_wr_en), 64'd1);
    #2 i_rst = 1'b0;
    #1;
    check("t6_rst_wr_en", 64'(o_wr_en), 64'd0);
    check("t6_rst_count", 64'(o_fifo_count), 64'd0);
    check("t6_rst_ready", 64'(o_cmd_ready), 64'd1);
    i_rst = 1'b1;
    tick();
    push(2'b01, 1'b0, 4'd0, w);
    start = wr_len;
    add_run(0, 1); add_run(1, 4); add_run(0, 2);
    check_pattern("t6_wr_en", start);

    // freeze mid-WAIT for 3 cycles
    push(2'b01, 1'b1, 4'd4, w);
    start = wr_len;
    repeat (2) tick();
    i_enable = 1'b0;
    #1;
    check("t7_ready_off", 64'(o_cmd_ready), 64'd0);
    repeat (3) tick();
    check("t7_frozen", 64'({o_busy, o_wr_en, o_fifo_count}), 64'b10000);
    i_enable = 1'b1;
    add_run(0, 8); add_run(1, 5); add_run(0, 2);
    check_pattern("t7_wr_en", start);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
